// File: rtl/toggle_hs_pkg.sv
// Shared types and default constants for the toggle-handshake responder.
package toggle_hs_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int XFER_CNT_W = 16;

  typedef enum logic {
    IDLE       = 1'b0,
    WAIT_SPACE = 1'b1
  } state_e;

endpackage

// File: rtl/toggle_hs_responder_if.sv
// Bus bundle between the initiator/consumer side and the responder.
interface toggle_hs_responder_if
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  logic                      req_tgl;
  logic [DATA_W-1:0]         req_data;
  logic                      ack_tgl;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_ready;
  logic [XFER_CNT_W-1:0]     xfer_cnt;
  logic [$clog2(DEPTH):0]    fifo_level;

  // Initiator and consumer side of the bus.
  modport master (
    output req_tgl, req_data, out_ready,
    input  ack_tgl, out_valid, out_data, xfer_cnt, fifo_level
  );

  // Responder side of the bus.
  modport slave (
    input  req_tgl, req_data, out_ready,
    output ack_tgl, out_valid, out_data, xfer_cnt, fifo_level
  );

endinterface

// File: rtl/hs_fifo.sv
// Show-ahead FIFO with power-of-two depth; pointers wrap naturally.
module hs_fifo
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Qualify requests: pop never underflows, push into a full FIFO only alongside a pop.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/toggle_hs_responder.sv
// Toggle-handshake responder: synchronises req_tgl, acknowledges each level
// change by toggling ack_tgl, and queues the offered word into an output FIFO.
module toggle_hs_responder
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  toggle_hs_responder_if.slave   bus
);

  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   req_seen_q, req_seen_d;
  logic                   ack_q, ack_d;
  logic [XFER_CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  state_e                 state_q, state_d;

  logic                   pending, push_ok, accept, pop;
  logic                   fifo_full, fifo_empty;
  logic [DATA_W-1:0]      fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_level;

  hs_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .wdata (bus.req_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.ack_tgl    = ack_q;
  assign bus.out_valid  = ~fifo_empty;
  assign bus.out_data   = fifo_rdata;
  assign bus.xfer_cnt   = xfer_cnt_q;
  assign bus.fifo_level = fifo_level;

  // Next-state and handshake decisions; a full FIFO still accepts when a pop frees a slot on the same edge.
  always_comb begin
    sync1_d    = bus.req_tgl;
    sync2_d    = sync1_q;
    pop        = ~fifo_empty & bus.out_ready;
    pending    = sync2_q ^ req_seen_q;
    push_ok    = ~fifo_full | pop;
    accept     = pending & push_ok;
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      IDLE:       if (pending && !push_ok) state_d = WAIT_SPACE;
      WAIT_SPACE: if (push_ok)             state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
    if (accept) begin
      req_seen_d = sync2_q;
      ack_d      = ~ack_q;
      xfer_cnt_d = xfer_cnt_q + 1'b1;
    end
  end

  // Synchroniser, handshake bookkeeping and FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      xfer_cnt_q <= '0;
      state_q    <= IDLE;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      xfer_cnt_q <= xfer_cnt_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_toggle_hs_responder.sv
// Directed bench for toggle_hs_responder with a queue-based output scoreboard.
module tb_toggle_hs_responder;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  logic       ack_exp = 1'b0;

  toggle_hs_responder_if #(.DATA_W(8), .DEPTH(4)) bus ();

  toggle_hs_responder #(.DATA_W(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every consumed word must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mon_unexpected actual=%0h required=none", bus.out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out_data !== e) begin
          failures++;
          $display("FAIL mon_data actual=%0h required=%0h", bus.out_data, e);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] d);
    bus.req_data = d;
    bus.req_tgl  = ~bus.req_tgl;
    exp_q.push_back(d);
  endtask

  task automatic wait_ack(input string name);
    ack_exp = ~ack_exp;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.ack_tgl == ack_exp) break;
    end
    check(name, 32'(bus.ack_tgl), 32'(ack_exp));
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_tgl   = 1'b0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    ack_exp = 1'b0;
    #1;
    check("rst_ack",   32'(bus.ack_tgl),    0);
    check("rst_valid", 32'(bus.out_valid),  0);
    check("rst_level", 32'(bus.fifo_level), 0);
    check("rst_cnt",   32'(bus.xfer_cnt),   0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_tgl   = 1'b0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    #2;
    do_reset();

    // Single transfer with exact latency
    issue(8'hA5);
    @(posedge clk); @(posedge clk); #1;
    check("lat_early_ack", 32'(bus.ack_tgl), 0);
    @(posedge clk); #1;
    ack_exp = 1'b1;
    check("lat_ack",   32'(bus.ack_tgl),   1);
    check("one_valid", 32'(bus.out_valid), 1);
    check("one_data",  32'(bus.out_data),  32'h A5);
    check("one_cnt",   32'(bus.xfer_cnt),  1);
    check("one_level", 32'(bus.fifo_level), 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("one_drain_level", 32'(bus.fifo_level), 0);
    check("one_drain_valid", 32'(bus.out_valid),  0);

    // Fill, then a fifth request must wait for space
    for (int i = 1; i <= 4; i++) begin
      issue(8'(i));
      wait_ack("fill_ack");
    end
    check("fill_level", 32'(bus.fifo_level), 4);
    check("fill_cnt",   32'(bus.xfer_cnt),   5);
    issue(8'h05);
    repeat (6) @(posedge clk);
    #1;
    check("wait_no_ack", 32'(bus.ack_tgl),    32'(ack_exp));
    check("wait_level",  32'(bus.fifo_level), 4);
    check("wait_cnt",    32'(bus.xfer_cnt),   5);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    ack_exp = ~ack_exp;
    check("wait_rel_ack",   32'(bus.ack_tgl),    32'(ack_exp));
    check("wait_rel_level", 32'(bus.fifo_level), 4);
    check("wait_rel_cnt",   32'(bus.xfer_cnt),   6);

    // Full FIFO, pending request meets a pop on the same edge from IDLE
    issue(8'h06);
    @(posedge clk); @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    ack_exp = ~ack_exp;
    check("simul_ack",   32'(bus.ack_tgl),    32'(ack_exp));
    check("simul_level", 32'(bus.fifo_level), 4);
    check("simul_cnt",   32'(bus.xfer_cnt),   7);
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("drain_level", 32'(bus.fifo_level), 0);
    check("drain_valid", 32'(bus.out_valid),  0);
    check("drain_sb",    32'(exp_q.size()),   0);

    // Ten streaming transfers wrap the pointers
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(8'h10 + 8'(i));
      wait_ack("stream_ack");
    end
    repeat (3) @(posedge clk);
    #1;
    check("stream_cnt",   32'(bus.xfer_cnt),   10);
    check("stream_level", 32'(bus.fifo_level), 0);
    check("stream_sb",    32'(exp_q.size()),   0);

    // Counter wrap from all-ones
    force dut.xfer_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.xfer_cnt_q;
    check("preload_cnt", 32'(bus.xfer_cnt), 32'h FFFF);
    issue(8'h3C);
    wait_ack("wrap_ack");
    check("wrap_cnt", 32'(bus.xfer_cnt), 0);
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset while waiting for space discards the request
    for (int i = 0; i < 4; i++) begin
      issue(8'h21 + 8'(i));
      wait_ack("pre_rst_ack");
    end
    issue(8'h25);
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_no_ack", 32'(bus.ack_tgl), 32'(ack_exp));
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_ack",   32'(bus.ack_tgl),    0);
    check("post_rst_cnt",   32'(bus.xfer_cnt),   0);
    check("post_rst_valid", 32'(bus.out_valid),  0);

    // Pop attempts on an empty FIFO
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("empty_pop_level", 32'(bus.fifo_level), 0);
    check("empty_pop_valid", 32'(bus.out_valid),  0);
    bus.out_ready = 1'b0;
    check("final_sb", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_hs_responder.md
TOGGLE_HS_RESPONDER -- requirements
Module: toggle_hs_responder

Interface
REQ-001 Parameter DATA_W, default 8, is the width of the transferred word.
REQ-002 Parameter DEPTH, default 4, is the number of output FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  is the reset: asynchronous, active-high.
REQ-005 req_tgl  input  1  is the request toggle from the initiator; each level change is one transfer request.
REQ-006 req_data  input  DATA_W  is the word offered by the initiator; it is held stable from the req_tgl change until the matching ack_tgl change.
REQ-007 ack_tgl  output  1  is the acknowledge toggle; each level change accepts exactly one request.
REQ-008 out_valid  output  1  means the FIFO head word is available.
REQ-009 out_data  output  DATA_W  is the FIFO head word; it is valid only while out_valid=1.
REQ-010 out_ready  input  1  means the consumer takes the head word on this edge when out_valid=1.
REQ-011 xfer_cnt  output  16  is the count of accepted transfers.
REQ-012 fifo_level  output  $clog2(DEPTH)+1  is the current number of FIFO entries.

Function
REQ-013 req_tgl SHALL pass through a 2-flop synchronizer (sync1, sync2) before any use.
REQ-014 A request is pending when sync2 differs from the internal register req_seen.
REQ-015 FSM states SHALL be IDLE and WAIT_SPACE.
REQ-016 IDLE with a pending request and push permitted: push req_data, toggle ack_tgl, set req_seen=sync2, increment xfer_cnt, all on the same edge; remain in IDLE.
REQ-017 IDLE with a pending request and push not permitted: go to WAIT_SPACE, with no push and no ack.
REQ-018 WAIT_SPACE: on the first edge where push is permitted, perform the REQ-016 actions and return to IDLE.
REQ-019 Push is permitted when fifo_level<DEPTH, or when fifo_level=DEPTH with out_valid=1 and out_ready=1 on the same edge (simultaneous pop).
REQ-020 Latency: a req_tgl change sampled at edge N SHALL produce the push and ack_tgl toggle at edge N+2 when push is permitted, and out_valid=1 after that edge if the FIFO was empty.
REQ-021 The FIFO SHALL be show-ahead: out_data equals the oldest entry whenever out_valid=1.
REQ-022 A pop occurs iff out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-023 A simultaneous push and pop SHALL leave fifo_level unchanged and preserve order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 xfer_cnt SHALL wrap from 16'hFFFF to 0.
REQ-026 ack_tgl SHALL change at most once per pending request; no second request is recognised until req_seen has been updated.
REQ-027 Data is never dropped; backpressure is applied only by withholding ack_tgl.

Reset
REQ-028 Reset SHALL immediately clear sync1, sync2, req_seen, ack_tgl, xfer_cnt, the FIFO pointers and fifo_level to 0; state SHALL become IDLE; out_valid SHALL become 0.
REQ-029 Reset during WAIT_SPACE or mid-synchronization SHALL discard the pending request without an ack.
REQ-030 The initiator shares the same reset, so req_tgl=0 while reset is asserted; no spurious request follows deassertion.

Structure
REQ-031 Package toggle_hs_pkg SHALL hold the FSM state enum, the default DATA_W/DEPTH constants and the xfer_cnt width.
REQ-032 The FIFO SHALL be the single sub-module hs_fifo (parameters DATA_W and DEPTH; push, pop, full, empty, level).

Verification
REQ-033 Single transfer: reset, req_data=8'hA5, toggle req_tgl 0->1 -> ack_tgl 0->1 two edges later; out_valid=1, out_data=8'hA5, xfer_cnt=1.
REQ-034 Fill with out_ready=0: send 8'h01..8'h04 -> fifo_level=4; a fifth request 8'h05 -> WAIT_SPACE with ack_tgl unchanged; one pop -> 8'h05 pushed, ack toggles, fifo_level stays 4.
REQ-035 Full with simultaneous pop: fifo_level=4, pending request and out_ready=1 on the same edge -> push and pop together, ack toggles, order 01,02,03,04,05 preserved.
REQ-036 Wrap: 10 back-to-back transfers with out_ready=1 -> outputs match inputs in order; xfer_cnt=10; preloading xfer_cnt to 16'hFFFF then one transfer -> 0.
REQ-037 Reset mid-operation: assert reset in WAIT_SPACE -> ack_tgl=0, out_valid=0, fifo_level=0, xfer_cnt=0; no ack for the discarded request.
REQ-038 Empty pop: out_ready=1 with fifo_level=0 -> fifo_level stays 0 and out_valid stays 0.
